// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the multicycle ALU.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_mul_unit.sv
// Shift-add multiplier: one multiplier bit per step, low WIDTH bits of the product kept.
module alu_mul_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product_next,
    output logic             last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    // product_next is the accumulator after the current step; on the last
    // step it is the finished product, so the top can register it directly.
    assign product_next = acc + (mplier[0] ? mcand : '0);
    assign last         = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= product_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic ops, optional WIDTH-cycle shift-add MUL.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 111 yields 0.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             alu_reset_n,
    input  logic             alu_start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_status_Z,
    output logic             alu_status_N,
    output logic             alu_status_wr,
    output logic             alu_done,
    output logic             alu_busy
);

    alu_state_t       state;
    alu_state_t       state_next;
    alu_op_t          op_in;
    logic [WIDTH-1:0] quick_result;
    logic [WIDTH-1:0] result_next;
    logic             result_load;
    logic             is_mul;

    assign op_in = alu_op_t'(alu_op);

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mul_product;
    logic             mul_last;
    logic             mul_load;
    logic             mul_step;

    assign is_mul = (op_in == ALU_MUL);

    alu_mul_unit #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clock       (clock),
        .reset_n     (alu_reset_n),
        .load        (mul_load),
        .step        (mul_step),
        .a           (alu_a),
        .b           (alu_b),
        .product_next(mul_product),
        .last        (mul_last)
    );
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle ops are evaluated straight from the inputs on the start edge.
    always_comb begin
        quick_result = '0;
        case (op_in)
            ALU_ADD: quick_result = alu_a + alu_b;
            ALU_SUB: quick_result = alu_a - alu_b;
            ALU_AND: quick_result = alu_a & alu_b;
            ALU_OR:  quick_result = alu_a | alu_b;
            ALU_XOR: quick_result = alu_a ^ alu_b;
            ALU_NOT: quick_result = ~alu_a;
            ALU_SHR: quick_result = alu_a >> 1;
            default: quick_result = '0;
        endcase
    end

    always_comb begin
        state_next  = state;
        result_load = 1'b0;
        result_next = quick_result;
`ifdef ALU_MUL_EN
        mul_load    = 1'b0;
        mul_step    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (alu_start) begin
                    if (is_mul) begin
                        state_next = EXEC;
`ifdef ALU_MUL_EN
                        mul_load   = 1'b1;
`endif
                    end else begin
                        state_next  = DONE;
                        result_load = 1'b1;
                    end
                end
            end
`ifdef ALU_MUL_EN
            EXEC: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_next  = DONE;
                    result_load = 1'b1;
                    result_next = mul_product;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!alu_reset_n) begin
            state        <= IDLE;
            alu_result   <= '0;
            alu_status_Z <= 1'b0;
            alu_status_N <= 1'b0;
        end else begin
            state <= state_next;
            if (result_load) begin
                alu_result   <= result_next;
                alu_status_Z <= (result_next == '0);
                alu_status_N <= result_next[WIDTH-1];
            end
        end
    end

    assign alu_done      = (state == DONE);
    assign alu_status_wr = (state == DONE);
    assign alu_busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against a behavioural model (honours ALU_MUL_EN).
module tb_alu_multicycle;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          alu_reset_n = 1'b0;
    logic          alu_start = 1'b0;
    logic [2:0]    alu_op = '0;
    logic [W-1:0]  alu_a = '0;
    logic [W-1:0]  alu_b = '0;
    logic [W-1:0]  alu_result;
    logic          alu_status_Z, alu_status_N, alu_status_wr, alu_done, alu_busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [1:0] status_reg = 2'b00;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Downstream status register fed by {Z,N} on status_wr.
    always @(posedge clock) begin
        if (!alu_reset_n) status_reg <= 2'b00;
        else if (alu_status_wr) status_reg <= {alu_status_Z, alu_status_N};
    end

    alu_multicycle #(.WIDTH(W)) dut (
        .clock        (clock),
        .alu_reset_n  (alu_reset_n),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_status_Z (alu_status_Z),
        .alu_status_N (alu_status_N),
        .alu_status_wr(alu_status_wr),
        .alu_done     (alu_done),
        .alu_busy     (alu_busy)
    );

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned ua, ub, r;
        ua = a;
        ub = b;
        case (op)
            3'd0: r = (ua + ub) % 65536;
            3'd1: r = (ua + 65536 - ub) % 65536;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 65535 - ua;
            3'd6: r = ua / 2;
            default: r = MUL_EN ? (ua * ub) % 65536 : 0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        return (op == 3'd7 && MUL_EN) ? W + 1 : 1;
    endfunction

    // Stimulus driver: entered and left at posedge+1. Scrambles inputs after the
    // start edge and optionally pulses start mid-flight; observations returned.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mid_start, output int lat, output logic [W-1:0] res,
                         output logic z, output logic n, output bit pulse_ok,
                         output bit busy_ok, output bit hold_ok);
        alu_start = 1'b1;
        alu_op = op;
        alu_a = a;
        alu_b = b;
        @(posedge clock); #1;
        alu_start = 1'b0;
        alu_op = 3'($urandom);
        alu_a = W'($urandom);
        alu_b = W'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (alu_done !== 1'b1 && lat < 40) begin
            if (alu_busy !== 1'b1) busy_ok = 1'b0;
            alu_start = (mid_start && lat == 5);
            @(posedge clock); #1;
            lat++;
        end
        alu_start = 1'b0;
        if (alu_busy !== 1'b1) busy_ok = 1'b0;
        res = alu_result;
        z = alu_status_Z;
        n = alu_status_N;
        pulse_ok = (alu_status_wr === 1'b1);
        @(posedge clock); #1;
        pulse_ok = pulse_ok && alu_done === 1'b0 && alu_status_wr === 1'b0 && alu_busy === 1'b0;
        hold_ok = ({alu_result, alu_status_Z, alu_status_N} === {res, z, n});
    endtask

    task automatic test_reset();
        alu_reset_n = 1'b0;
        alu_start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        compared++;
        if ({alu_result, alu_status_Z, alu_status_N, alu_done, alu_status_wr, alu_busy} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got res=%h Z=%b N=%b done=%b wr=%b busy=%b want all 0",
                     alu_result, alu_status_Z, alu_status_N, alu_done, alu_status_wr, alu_busy);
        end
        alu_start = 1'b0;
        alu_reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mid;
        logic [W-1:0] res;
        logic         z;
        logic         n;
    } vec_t;

    task automatic test_directed();
        vec_t q[$];
        int lat;
        logic [W-1:0] res;
        logic z, n;
        bit pok, bok, hok;
        q.push_back('{op: 3'd0, a: 16'h0005, b: 16'hFFFB, mid: 1'b0, res: 16'h0000, z: 1'b1, n: 1'b0});
        q.push_back('{op: 3'd1, a: 16'h0003, b: 16'h0005, mid: 1'b0, res: 16'hFFFE, z: 1'b0, n: 1'b1});
        q.push_back('{op: 3'd5, a: 16'h00FF, b: 16'h1234, mid: 1'b0, res: 16'hFF00, z: 1'b0, n: 1'b1});
        q.push_back('{op: 3'd6, a: 16'h8001, b: 16'h0000, mid: 1'b0, res: 16'h4000, z: 1'b0, n: 1'b0});
`ifdef ALU_MUL_EN
        q.push_back('{op: 3'd7, a: 16'h0123, b: 16'h0010, mid: 1'b1, res: 16'h1230, z: 1'b0, n: 1'b0});
        q.push_back('{op: 3'd7, a: 16'h8000, b: 16'h0002, mid: 1'b0, res: 16'h0000, z: 1'b1, n: 1'b0});
`else
        q.push_back('{op: 3'd7, a: 16'h1234, b: 16'h5678, mid: 1'b0, res: 16'h0000, z: 1'b1, n: 1'b0});
`endif
        foreach (q[i]) begin
            do_op(q[i].op, q[i].a, q[i].b, q[i].mid, lat, res, z, n, pok, bok, hok);
            compared++;
            if ({res, z, n} !== {q[i].res, q[i].z, q[i].n}) begin
                mismatched++;
                $display("FAIL dir%0d_result: got %h Z=%b N=%b want %h Z=%b N=%b",
                         i, res, z, n, q[i].res, q[i].z, q[i].n);
            end
            compared++;
            if (lat !== exp_lat(q[i].op)) begin
                mismatched++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(q[i].op));
            end
            compared++;
            if (!(pok && bok && hok)) begin
                mismatched++;
                $display("FAIL dir%0d_handshake: got pulse=%0d busy=%0d hold=%0d want 1 1 1", i, pok, bok, hok);
            end
            compared++;
            if (status_reg !== {q[i].z, q[i].n}) begin
                mismatched++;
                $display("FAIL dir%0d_status_reg: got %b want %b", i, status_reg, {q[i].z, q[i].n});
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] res, a, b, exp;
        logic [2:0] op;
        logic z, n;
        bit pok, bok, hok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: a = 16'h8000;
                default: a = W'($urandom);
            endcase
            b = ($urandom_range(0, 4) == 0) ? 16'h0000 : W'($urandom);
            do_op(op, a, b, bit'($urandom_range(0, 1)), lat, res, z, n, pok, bok, hok);
            exp = model(op, a, b);
            compared++;
            if ({res, z, n} !== {exp, exp == 0, exp[W-1]}) begin
                mismatched++;
                $display("FAIL rnd%0d_op%0d_result: got %h Z=%b N=%b want %h (a=%h b=%h)", i, op, res, z, n, exp, a, b);
            end
            compared++;
            if (lat !== exp_lat(op) || !(pok && bok && hok)) begin
                mismatched++;
                $display("FAIL rnd%0d_op%0d_timing: got lat=%0d pulse=%0d busy=%0d hold=%0d want lat=%0d 1 1 1",
                         i, op, lat, pok, bok, hok, exp_lat(op));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, c0;
        logic [W-1:0] res, a, b, exp;
        logic [2:0] op;
        logic z, n;
        bit pok, bok, hok;
        bit ok = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(0, 6));
            a = W'($urandom);
            b = W'($urandom);
            do_op(op, a, b, 1'b0, lat, res, z, n, pok, bok, hok);
            exp = model(op, a, b);
            if (res !== exp || lat !== 1 || !pok) ok = 1'b0;
        end
        compared++;
        if (!ok || (cyc - c0) !== 12) begin
            mismatched++;
            $display("FAIL back_to_back: got ok=%0d cycles=%0d want ok=1 cycles=12", ok, cyc - c0);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [W-1:0] res;
        logic z, n;
        bit pok, bok, hok;
        bit pulsed = 1'b0;
        do_op(3'd0, 16'h0001, 16'h0001, 1'b0, lat, res, z, n, pok, bok, hok);
        alu_start = 1'b1;
        alu_op = 3'd7;
        alu_a = 16'h0123;
        alu_b = 16'h0011;
        @(posedge clock); #1;
        alu_start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        alu_reset_n = 1'b0;
        alu_start = 1'b1;
        alu_op = 3'd0;
        @(posedge clock); #1;
        compared++;
        if ({alu_result, alu_status_Z, alu_status_N, alu_done, alu_status_wr, alu_busy} !== '0) begin
            mismatched++;
            $display("FAIL abort_outputs: got res=%h Z=%b N=%b done=%b wr=%b busy=%b want all 0",
                     alu_result, alu_status_Z, alu_status_N, alu_done, alu_status_wr, alu_busy);
        end
        alu_start = 1'b0;
        alu_reset_n = 1'b1;
        repeat (25) begin
            @(posedge clock); #1;
            if (alu_done !== 1'b0 || alu_status_wr !== 1'b0 || alu_busy !== 1'b0) pulsed = 1'b1;
        end
        compared++;
        if (pulsed) begin
            mismatched++;
            $display("FAIL abort_no_done: got late pulse/busy=1 want 0");
        end
        do_op(3'd2, 16'hF0F0, 16'h0FF0, 1'b0, lat, res, z, n, pok, bok, hok);
        compared++;
        if ({res, z, n, lat} !== {16'h00F0, 1'b0, 1'b0, 32'd1} || !pok) begin
            mismatched++;
            $display("FAIL after_abort_and: got %h Z=%b N=%b lat=%0d pulse=%0d want 00f0 Z=0 N=0 lat=1 pulse=1",
                     res, z, n, lat, pok);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
